ternary_sdm_mod: RTL and testbench

TERNARY_SDM_MOD -- requirements
Module: ternary_sdm_mod

---
 rtl/ternary_sdm_mod_pkg.sv | 22 ++
 rtl/ternary_sdm_mod_if.sv | 30 +++
 rtl/sdm_sat_integrator.sv | 57 +++++
 rtl/ternary_sdm_mod.sv | 159 +++++++++++++++
 tb/tb_ternary_sdm_mod.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ternary_sdm_mod_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sdm_pkg
//  Purpose  : Shared defaults and 1.5-bit drive codes for the ternary
//             second-order sigma-delta modulator.
//  Revision : 1.0  initial release
// ============================================================================
package sdm_pkg;

    localparam int SDM_DATA_W   = 16;
    localparam int SDM_OSR_LOG2 = 6;
    localparam int SDM_ACC_W    = SDM_DATA_W + 4;

    // Drive code is {out_p, out_n}; 2'b11 is never produced.
    typedef logic [1:0] drv_t;

    localparam drv_t DRV_ZERO = 2'b00;
    localparam drv_t DRV_POS  = 2'b10;
    localparam drv_t DRV_NEG  = 2'b01;

endpackage : sdm_pkg
`default_nettype wire

// File: rtl/ternary_sdm_mod_if.sv
`default_nettype none
// ============================================================================
//  Module   : ternary_sdm_mod_if
//  Purpose  : PCM sample handshake between a sample source and the modulator.
//  Revision : 1.0  initial release
// ============================================================================
interface ternary_sdm_mod_if
    import sdm_pkg::*;
#(
    parameter int DATA_W = SDM_DATA_W
);
    logic signed [DATA_W-1:0] sample_data;
    logic                     sample_valid;
    logic                     sample_ready;

    // Sample source side
    modport master (
        output sample_data,
        output sample_valid,
        input  sample_ready
    );

    // Modulator side
    modport slave (
        input  sample_data,
        input  sample_valid,
        output sample_ready
    );
endinterface : ternary_sdm_mod_if
`default_nettype wire

// File: rtl/sdm_sat_integrator.sv
`default_nettype none
// ============================================================================
//  Module   : sdm_sat_integrator
//  Purpose  : Signed accumulator with saturation to the ACC_W range and a
//             per-cycle clip indication. Held at zero while i_en is low.
//  Revision : 1.0  initial release
// ============================================================================
module sdm_sat_integrator
    import sdm_pkg::*;
#(
    parameter int ACC_W = SDM_ACC_W
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    i_en,
    input  wire logic signed [ACC_W:0]   i_delta,
    output logic signed [ACC_W-1:0]      o_acc,
    output logic signed [ACC_W-1:0]      o_acc_next,
    output logic                         o_clip
);

    localparam logic signed [ACC_W-1:0] c_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W+1:0] w_sum;
    logic                    w_clip;
    logic signed [ACC_W-1:0] w_next;

    // Two guard bits make the sum exact; it fits ACC_W only when the top three bits agree
    always_comb begin
        w_sum  = {{2{r_acc[ACC_W-1]}}, r_acc} + {i_delta[ACC_W], i_delta};
        w_clip = !((w_sum[ACC_W+1:ACC_W-1] == 3'b000) ||
                   (w_sum[ACC_W+1:ACC_W-1] == 3'b111));
        w_next = w_sum[ACC_W-1:0];
        if (w_clip) begin
            w_next = w_sum[ACC_W+1] ? c_MIN : c_MAX;
        end
    end

    // Accumulator register, cleared whenever the modulator is idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (!i_en) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_next;
        end
    end

    assign o_acc      = r_acc;
    assign o_acc_next = w_next;
    assign o_clip     = w_clip;

endmodule : sdm_sat_integrator
`default_nettype wire

// File: rtl/ternary_sdm_mod.sv
`default_nettype none
// ============================================================================
//  Module   : ternary_sdm_mod
//  Purpose  : Second-order sigma-delta modulator with a three-level
//             (+FS / 0 / -FS) registered output, zero-order-held PCM input,
//             and sticky underrun / overload flags.
//  Revision : 1.0  initial release
// ============================================================================
module ternary_sdm_mod
    import sdm_pkg::*;
#(
    parameter int DATA_W   = SDM_DATA_W,
    parameter int OSR_LOG2 = SDM_OSR_LOG2,
    parameter int ACC_W    = DATA_W + 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          enable,
    input  wire logic          clr_flags,
    ternary_sdm_mod_if.slave   s_if,
    output logic               out_p,
    output logic               out_n,
    output logic               underrun,
    output logic               overload
);

    localparam logic [OSR_LOG2-1:0] c_TICK_LAST = {OSR_LOG2{1'b1}};
    // Full-scale feedback magnitude 2^(DATA_W-1), in the error-path width
    localparam logic signed [ACC_W:0] c_FS =
        {{(ACC_W+1-DATA_W){1'b0}}, 1'b1, {(DATA_W-1){1'b0}}};
    // Quantizer threshold 2^(DATA_W-2), in accumulator width
    localparam logic signed [ACC_W-1:0] c_TH =
        {{(ACC_W-DATA_W+1){1'b0}}, 1'b1, {(DATA_W-2){1'b0}}};
    localparam logic signed [ACC_W-1:0] c_NTH = -c_TH;

    logic [OSR_LOG2-1:0]      r_tick;
    logic signed [DATA_W-1:0] r_x_hold;
    drv_t                     r_drv;
    logic                     r_underrun;
    logic                     r_overload;

    logic                     w_ready;
    logic                     w_accept;
    logic                     w_miss;
    logic signed [ACC_W:0]    w_fb;
    logic signed [ACC_W:0]    w_x_ext;
    logic signed [ACC_W:0]    w_i1_ext;
    logic signed [ACC_W:0]    w_diff1;
    logic signed [ACC_W:0]    w_diff2;
    logic signed [ACC_W:0]    w_d1;
    logic signed [ACC_W:0]    w_d2;
    logic signed [ACC_W-1:0]  w_i1;
    logic signed [ACC_W-1:0]  w_i1_next;
    logic signed [ACC_W-1:0]  w_i2;
    logic signed [ACC_W-1:0]  w_i2_next;
    logic                     w_clip1;
    logic                     w_clip2;
    drv_t                     w_q;
    logic                     w_unused;

    assign w_ready  = enable && (r_tick == c_TICK_LAST);
    assign w_accept = w_ready && s_if.sample_valid;
    assign w_miss   = w_ready && !s_if.sample_valid;

    // Feedback value from the current drive code and both loop error terms
    always_comb begin
        w_fb = '0;
        if (r_drv == DRV_POS) begin
            w_fb = c_FS;
        end else if (r_drv == DRV_NEG) begin
            w_fb = -c_FS;
        end
        w_x_ext  = {{(ACC_W+1-DATA_W){r_x_hold[DATA_W-1]}}, r_x_hold};
        w_i1_ext = {w_i1[ACC_W-1], w_i1};
        w_diff1  = w_x_ext - w_fb;
        w_diff2  = w_i1_ext - w_fb;
        w_d1     = w_diff1 >>> 1;
        w_d2     = w_diff2 >>> 1;
    end

    sdm_sat_integrator #(.ACC_W(ACC_W)) u_int1 (
        .clk        (clk),
        .rst        (rst),
        .i_en       (enable),
        .i_delta    (w_d1),
        .o_acc      (w_i1),
        .o_acc_next (w_i1_next),
        .o_clip     (w_clip1)
    );

    sdm_sat_integrator #(.ACC_W(ACC_W)) u_int2 (
        .clk        (clk),
        .rst        (rst),
        .i_en       (enable),
        .i_delta    (w_d2),
        .o_acc      (w_i2),
        .o_acc_next (w_i2_next),
        .o_clip     (w_clip2)
    );

    // Next i1 and the registered i2 are not consumed by the loop
    assign w_unused = ^{w_i1_next, w_i2};

    // Three-level quantizer applied to the value i2 takes this cycle
    always_comb begin
        w_q = DRV_ZERO;
        if (w_i2_next >= c_TH) begin
            w_q = DRV_POS;
        end else if (w_i2_next < c_NTH) begin
            w_q = DRV_NEG;
        end
    end

    // Sample-period counter, held input sample and registered drive code
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick   <= '0;
            r_x_hold <= '0;
            r_drv    <= DRV_ZERO;
        end else if (!enable) begin
            r_tick   <= '0;
            r_x_hold <= '0;
            r_drv    <= DRV_ZERO;
        end else begin
            r_tick <= r_tick + OSR_LOG2'(1);
            r_drv  <= w_q;
            if (w_accept) begin
                r_x_hold <= s_if.sample_data;
            end
        end
    end

    // Sticky flags: clear first, so a same-cycle set event overrides it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underrun <= 1'b0;
            r_overload <= 1'b0;
        end else begin
            if (clr_flags) begin
                r_underrun <= 1'b0;
                r_overload <= 1'b0;
            end
            if (w_miss) begin
                r_underrun <= 1'b1;
            end
            if (enable && (w_clip1 || w_clip2)) begin
                r_overload <= 1'b1;
            end
        end
    end

    assign s_if.sample_ready = w_ready;
    assign out_p             = r_drv[1];
    assign out_n             = r_drv[0];
    assign underrun          = r_underrun;
    assign overload          = r_overload;

endmodule : ternary_sdm_mod
`default_nettype wire

// File: tb/tb_ternary_sdm_mod.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ternary_sdm_mod
//  Purpose  : Self-checking bench for ternary_sdm_mod: integer reference model
//             compared every cycle, plus directed scenarios with literal
//             expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ternary_sdm_mod;

    localparam int    OSR  = 64;
    localparam longint FS   = 32768;
    localparam longint TH   = 16384;
    localparam longint AMAX = 524287;
    localparam longint AMIN = -524288;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic clr_flags = 1'b0;
    logic out_p, out_n, underrun, overload;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    ternary_sdm_mod_if #(.DATA_W(16)) sif ();

    ternary_sdm_mod #(.DATA_W(16), .OSR_LOG2(6), .ACC_W(20)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .clr_flags (clr_flags),
        .s_if      (sif),
        .out_p     (out_p),
        .out_n     (out_n),
        .underrun  (underrun),
        .overload  (overload)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (plain integer arithmetic) -----------
    int     m_tick;
    longint m_x, m_i1, m_i2;
    int     m_y;
    bit     m_und, m_ov;
    longint fb, a1, a2;
    bit     und_n, ov_n;

    function automatic longint half_floor(input longint v);
        if (v < 0 && (v % 2) != 0) return v / 2 - 1;
        return v / 2;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tick <= 0; m_x <= 0; m_i1 <= 0; m_i2 <= 0; m_y <= 0;
            m_und <= 1'b0; m_ov <= 1'b0;
        end else begin
            und_n = clr_flags ? 1'b0 : m_und;
            ov_n  = clr_flags ? 1'b0 : m_ov;
            if (!enable) begin
                m_tick <= 0; m_x <= 0; m_i1 <= 0; m_i2 <= 0; m_y <= 0;
            end else begin
                fb = m_y * FS;
                a1 = m_i1 + half_floor(m_x - fb);
                a2 = m_i2 + half_floor(m_i1 - fb);
                if (a1 > AMAX) begin a1 = AMAX; ov_n = 1'b1; end
                if (a1 < AMIN) begin a1 = AMIN; ov_n = 1'b1; end
                if (a2 > AMAX) begin a2 = AMAX; ov_n = 1'b1; end
                if (a2 < AMIN) begin a2 = AMIN; ov_n = 1'b1; end
                m_i1 <= a1;
                m_i2 <= a2;
                m_y  <= (a2 >= TH) ? 1 : ((a2 < -TH) ? -1 : 0);
                if (m_tick == OSR - 1) begin
                    if (sif.sample_valid) m_x <= longint'($signed(sif.sample_data));
                    else                  und_n = 1'b1;
                end
                m_tick <= (m_tick + 1) % OSR;
            end
            m_und <= und_n;
            m_ov  <= ov_n;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("drive", {out_p, out_n},
                (m_y == 1) ? 64'd2 : ((m_y == -1) ? 64'd1 : 64'd0));
            chk("ready", sif.sample_ready, (enable && m_tick == OSR - 1) ? 64'd1 : 64'd0);
            chk("underrun", underrun, m_und);
            chk("overload", overload, m_ov);
            chk("never_11", out_p & out_n, 0);
        end
    end

    // ---------------- helpers ---------------------------------------------
    task automatic wait_first_ready(input string name);
        int n = 0;
        while (sif.sample_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, n, 63);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (sif.sample_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_within_period", sif.sample_ready, 1);
    endtask

    // Called with sample_ready visible: next edge accepts, then 8192 cycles counted
    task automatic stream_dc(input string tag, input int sgn);
        int np, nn, diff;
        np = 0; nn = 0;
        @(posedge clk); #1;
        for (int k = 1; k <= 8192; k++) begin
            @(posedge clk); #1;
            np += int'(out_p);
            nn += int'(out_n);
            if (k == 3) chk({tag, "_step_k3"}, {out_p, out_n}, 0);
            if (k == 4) chk({tag, "_step_k4"}, {out_p, out_n}, (sgn > 0) ? 64'd2 : 64'd1);
        end
        diff = (sgn > 0) ? (np - nn) : (nn - np);
        total++;
        if (diff < 4080 || diff > 4112) begin
            bad++;
            $display("FAIL %s_density: got %0d expected 4096+-16", tag, diff);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ------------------------------------
    initial begin
        int nz, nr;
        sif.sample_data  = '0;
        sif.sample_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_drive", {out_p, out_n}, 0);
        chk("reset_ready", sif.sample_ready, 0);
        chk("reset_underrun", underrun, 0);
        chk("reset_overload", overload, 0);
        @(negedge clk); rst = 1'b0; chk_en = 1'b1;

        // Zero input streamed continuously
        @(negedge clk); enable = 1'b1; sif.sample_valid = 1'b1; sif.sample_data = 16'sd0;
        wait_first_ready("first_ready_after_enable");
        nz = 0;
        repeat (4096) begin @(posedge clk); #1; if (out_p || out_n) nz++; end
        chk("zero_in_outputs", nz, 0);
        chk("zero_in_underrun", underrun, 0);
        chk("zero_in_overload", overload, 0);

        // Half-scale positive DC
        @(negedge clk); sif.sample_data = 16'sd16384;
        wait_ready();
        stream_dc("pos", 1);

        // Half-scale negative DC from a cleared loop
        @(negedge clk); enable = 1'b0; sif.sample_data = -16'sd16384;
        repeat (10) begin @(posedge clk); #1; end
        chk("idle_drive", {out_p, out_n}, 0);
        chk("idle_ready", sif.sample_ready, 0);
        @(negedge clk); enable = 1'b1;
        wait_first_ready("first_ready_neg");
        stream_dc("neg", -1);

        // Missing sample at a period boundary; x_hold must not load the new data
        wait_ready();
        @(negedge clk); sif.sample_valid = 1'b0; sif.sample_data = 16'sd0;
        chk("underrun_before", underrun, 0);
        @(posedge clk); #1;
        chk("underrun_set", underrun, 1);
        @(negedge clk); sif.sample_valid = 1'b1; sif.sample_data = -16'sd16384;
        repeat (5) begin @(posedge clk); #1; end
        @(negedge clk); clr_flags = 1'b1;
        @(posedge clk); #1;
        chk("underrun_cleared", underrun, 0);
        @(negedge clk); clr_flags = 1'b0;

        // Clear and set in the same cycle: set wins
        wait_ready();
        @(negedge clk); sif.sample_valid = 1'b0; clr_flags = 1'b1;
        @(posedge clk); #1;
        chk("set_wins_over_clear", underrun, 1);
        @(negedge clk); sif.sample_valid = 1'b1; clr_flags = 1'b0;

        // Reset mid-period at tick 30
        wait_ready();
        repeat (31) begin @(posedge clk); #1; end
        @(negedge clk); rst = 1'b1;
        #1;
        chk("rst_drive", {out_p, out_n}, 0);
        chk("rst_ready", sif.sample_ready, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_overload", overload, 0);
        @(negedge clk); rst = 1'b0;
        wait_first_ready("first_ready_after_rst");

        // Flag retained across an enable drop; restart with zero input
        @(negedge clk); sif.sample_valid = 1'b0;
        wait_ready();
        @(posedge clk); #1;
        @(negedge clk); sif.sample_valid = 1'b1; enable = 1'b0; sif.sample_data = 16'sd0;
        nz = 0; nr = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_p || out_n) nz++;
            if (sif.sample_ready) nr++;
        end
        chk("disabled_outputs", nz, 0);
        chk("disabled_ready", nr, 0);
        chk("flag_retained", underrun, 1);
        @(negedge clk); enable = 1'b1;
        wait_first_ready("first_ready_reenable");
        nz = 0;
        repeat (200) begin @(posedge clk); #1; if (out_p || out_n) nz++; end
        chk("reenable_zero_outputs", nz, 0);
        @(negedge clk); clr_flags = 1'b1;
        @(posedge clk); #1;
        chk("final_clear", underrun, 0);
        @(negedge clk); clr_flags = 1'b0;

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ternary_sdm_mod
`default_nettype wire
